// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: packs 12-bit sample pairs into UART bytes and paces the TX.
// Define UART_TX_HEADER_EN to send HEADER_BYTE ahead of every frame.
module uart_tx_ctrl #(
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] din_12_a,
  input  logic [11:0] din_12_b,
  input  logic        din_12_valid,
  output logic        din_12_ready,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy,
  output logic        frame_done,
  output logic        ack_err,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO, S_GAP, S_DONE
  } state_e;

`ifdef UART_TX_HEADER_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd2;
`endif
  localparam logic [7:0] TO_MAX   = 8'(ACK_TIMEOUT);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] a_q, a_d;
  logic [11:0] b_q, b_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  to_q, to_d;
  logic [7:0]  gap_q, gap_d;
  logic        adv;
  logic [1:0]  sel;
  logic [7:0]  pick;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    ready_d = ready_q;
    err_d   = err_q;
    to_d    = to_q;
    gap_d   = gap_q;
    drop_d  = drop_q;
    adv     = 1'b0;
    if (din_12_valid && !ready_q && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    unique case (state_q)
      S_IDLE: begin
        if (din_12_valid && ready_q) begin
          a_d     = din_12_a;
          b_d     = din_12_b;
          idx_d   = 2'd0;
          ready_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        to_d    = 8'd0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (uart_tx_busy) begin
          state_d = S_WAIT_LO;
        end else begin
          to_d = to_q + 8'd1;
          if (to_d == TO_MAX) begin
            err_d = 1'b1;
            adv   = 1'b1;
          end
        end
      end
      S_WAIT_LO: begin
        if (!uart_tx_busy)
          adv = 1'b1;
      end
      S_GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GAP_LAST) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_START;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Byte finished (acked or timed out): close frame, pause, or go next.
    if (adv) begin
      if (idx_q == LAST) begin
        state_d = S_DONE;
      end else if (GAP_CYCLES == 0) begin
        idx_d   = idx_q + 2'd1;
        state_d = S_START;
      end else begin
        gap_d   = 8'd0;
        state_d = S_GAP;
      end
    end
  end

  always_comb begin
`ifdef UART_TX_HEADER_EN
    sel = idx_d;
`else
    sel = idx_d + 2'd1;
`endif
    unique case (sel)
      2'd0:    pick = HEADER_BYTE;
      2'd1:    pick = a_d[11:4];
      2'd2:    pick = {a_d[3:0], b_d[11:8]};
      default: pick = b_d[7:0];
    endcase
    data_d = (state_d == S_START) ? pick : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      a_q     <= 12'd0;
      b_q     <= 12'd0;
      data_q  <= 8'd0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      drop_q  <= 8'd0;
      to_q    <= 8'd0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
    end
  end

  assign din_12_ready = ready_q;
  assign uart_tx_en   = (state_q == S_START);
  assign uart_tx_data = data_q;
  assign frame_done   = (state_q == S_DONE);
  assign ack_err      = err_q;
  assign drop_cnt     = drop_q;

endmodule
